// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multicycle RISC-V datapath with retired-instruction counter
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             instr_done,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    BEQ      = 4'd9,
    TRAP     = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  state_t cur, nxt;
  logic [3:0] dec_op;
  logic dec_ok;
  logic pw, mw, iw, rw, done, trp;
  // state register; reset lands in FETCH immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  // retired-instruction counter, wraps freely
  always_ff @(posedge clk or posedge reset)
    if (reset) instret <= '0;
    else if (instr_done) instret <= instret + CNT_W'(1);
  // ALU function decode shared by EXECR and EXECI; only register-form add honours funct7_5
  always_comb begin
    dec_ok = 1'b1;
    dec_op = 4'b0010;
    case (funct3)
      3'b000: dec_op = (funct7_5 && cur == EXECR) ? 4'b0110 : 4'b0010;
      3'b111: dec_op = 4'b0000;
      3'b110: dec_op = 4'b0001;
      3'b101: begin
        dec_op = 4'b1010;
        dec_ok = !funct7_5;
      end
      default: dec_ok = 1'b0;
    endcase
  end
  // next-state and Moore output decode; pc_write in BEQ follows the zero flag
  always_comb begin
    nxt = cur;
    pw = 1'b0;
    adr_src = 1'b0;
    mw = 1'b0;
    iw = 1'b0;
    rw = 1'b0;
    result_src = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op = 4'b0010;
    done = 1'b0;
    trp = 1'b0;
    case (cur)
      FETCH: begin
        iw = 1'b1;
        pw = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        nxt = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
              (opcode == OP_R) ? EXECR :
              (opcode == OP_I) ? EXECI :
              (opcode == OP_BR && funct3 == 3'b000) ? BEQ : TRAP;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        rw = 1'b1;
        done = 1'b1;
        nxt = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mw = 1'b1;
        done = 1'b1;
        nxt = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = (cur == EXECI) ? 2'b01 : 2'b00;
        alu_op = dec_op;
        nxt = dec_ok ? ALUWB : TRAP;
      end
      ALUWB: begin
        rw = 1'b1;
        done = 1'b1;
        nxt = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op = 4'b0110;
        pw = zero;
        done = 1'b1;
        nxt = FETCH;
      end
      TRAP: trp = 1'b1;
      default: nxt = TRAP;
    endcase
  end
  assign pc_write   = pw & ~reset;
  assign mem_write  = mw & ~reset;
  assign ir_write   = iw & ~reset;
  assign reg_write  = rw & ~reset;
  assign instr_done = done & ~reset;
  assign trap       = trp & ~reset;
  assign state      = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scenario tests for the multicycle control FSM
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7_5 = 1'b0;
  logic zero = 1'b0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_op, state;
  logic [3:0] instret;
  logic [3:0] exp_ret = 4'd0;
  int total = 0;
  int bad = 0;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .trap(trap), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if ({pc_write, ir_write, reg_write, mem_write, instr_done, trap} !== 6'b0) begin bad++; $display("FAIL reset_strobes got=%b want=000000", {pc_write, ir_write, reg_write, mem_write, instr_done, trap}); end
    total++; if ({alu_src_a, alu_src_b, result_src, alu_op} !== 10'b00_10_10_0010) begin bad++; $display("FAIL reset_selects got=%b want=0010100010", {alu_src_a, alu_src_b, result_src, alu_op}); end
    total++; if (instret !== 4'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({pc_write, ir_write} !== 2'b11) begin bad++; $display("FAIL first_fetch got=%b want=11", {pc_write, ir_write}); end
  endtask

  task automatic test_rtype_sub();
    logic [3:0] es [5];
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (state !== es[i]) begin bad++; $display("FAIL rsub_state[%0d] got=%0d want=%0d", i, state, es[i]); end
      total++; if (reg_write !== 1'(i == 3)) begin bad++; $display("FAIL rsub_regwrite[%0d] got=%b want=%b", i, reg_write, i == 3); end
      if (i == 2) begin
        total++; if (alu_op !== 4'b0110) begin bad++; $display("FAIL rsub_aluop got=%b want=0110", alu_op); end
      end
      if (i < 4) cyc();
    end
    exp_ret++;
    total++; if (instret !== exp_ret) begin bad++; $display("FAIL rsub_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_lw_sw();
    logic [3:0] el [6];
    logic [3:0] es [5];
    int mw_cnt;
    el = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    mw_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      total++; if (state !== el[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, el[i]); end
      if (mem_write) mw_cnt++;
      if (i == 3) begin
        total++; if (adr_src !== 1'b1) begin bad++; $display("FAIL lw_adrsrc got=%b want=1", adr_src); end
      end
      if (i == 4) begin
        total++; if ({result_src, reg_write, instr_done} !== 4'b01_1_1) begin bad++; $display("FAIL lw_wb got=%b want=0111", {result_src, reg_write, instr_done}); end
      end
      if (i < 5) cyc();
    end
    total++; if (mw_cnt !== 0) begin bad++; $display("FAIL lw_memwrite got=%0d want=0", mw_cnt); end
    opcode = 7'b0100011;
    mw_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      total++; if (state !== es[i]) begin bad++; $display("FAIL sw_state[%0d] got=%0d want=%0d", i, state, es[i]); end
      total++; if (mem_write !== 1'(i == 3)) begin bad++; $display("FAIL sw_memwrite[%0d] got=%b want=%b", i, mem_write, i == 3); end
      if (mem_write) mw_cnt++;
      if (i < 4) cyc();
    end
    total++; if (mw_cnt !== 1) begin bad++; $display("FAIL sw_memwrite_cnt got=%0d want=1", mw_cnt); end
    exp_ret += 4'd2;
    total++; if (instret !== exp_ret) begin bad++; $display("FAIL lwsw_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_beq();
    logic [3:0] es [4];
    es = '{4'd0, 4'd1, 4'd9, 4'd0};
    for (int z = 1; z >= 0; z--) begin
      opcode = 7'b1100011; funct3 = 3'b000; zero = 1'(z);
      for (int i = 0; i < 4; i++) begin
        total++; if (state !== es[i]) begin bad++; $display("FAIL beq%0d_state[%0d] got=%0d want=%0d", z, i, state, es[i]); end
        if (i == 2) begin
          total++; if (pc_write !== 1'(z)) begin bad++; $display("FAIL beq%0d_pcwrite got=%b want=%0d", z, pc_write, z); end
          total++; if ({alu_op, instr_done, alu_src_a} !== 7'b0110_1_10) begin bad++; $display("FAIL beq%0d_ctl got=%b want=0110110", z, {alu_op, instr_done, alu_src_a}); end
        end
        if (i < 3) cyc();
      end
      exp_ret++;
    end
    zero = 1'b0;
    total++; if (instret !== exp_ret) begin bad++; $display("FAIL beq_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops [5];
    logic [2:0] f3s [5];
    logic f7s [5];
    logic [3:0] eop [5];
    logic [3:0] ex [5];
    ops = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0110011};
    f3s = '{3'b111, 3'b110, 3'b101, 3'b000, 3'b101};
    f7s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    eop = '{4'b0000, 4'b0001, 4'b1010, 4'b0010, 4'b1010};
    ex  = '{4'd6, 4'd8, 4'd8, 4'd8, 4'd6};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k]; funct3 = f3s[k]; funct7_5 = f7s[k];
      cyc(); cyc();
      total++; if (state !== ex[k]) begin bad++; $display("FAIL dec%0d_state got=%0d want=%0d", k, state, ex[k]); end
      total++; if (alu_op !== eop[k]) begin bad++; $display("FAIL dec%0d_aluop got=%b want=%b", k, alu_op, eop[k]); end
      total++; if (alu_src_b !== ((ex[k] == 4'd8) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL dec%0d_srcb got=%b", k, alu_src_b); end
      cyc();
      total++; if (state !== 4'd7) begin bad++; $display("FAIL dec%0d_aluwb got=%0d want=7", k, state); end
      cyc();
      exp_ret++;
    end
    total++; if (instret !== exp_ret) begin bad++; $display("FAIL dec_instret got=%0d want=%0d", instret, exp_ret); end
  endtask

  task automatic test_trap();
    logic [6:0] ops [5];
    logic [2:0] f3s [5];
    logic f7s [5];
    ops = '{7'b0010011, 7'b0110011, 7'b1101111, 7'b1100011, 7'b0110011};
    f3s = '{3'b101, 3'b001, 3'b000, 3'b001, 3'b101};
    f7s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      opcode = ops[k]; funct3 = f3s[k]; funct7_5 = f7s[k];
      cyc(); cyc(); cyc();
      for (int i = 0; i < 3; i++) begin
        total++; if (state !== 4'd10 || trap !== 1'b1) begin bad++; $display("FAIL trap%0d_state[%0d] got=%0d/%b want=10/1", k, i, state, trap); end
        total++; if ({pc_write, ir_write, reg_write, mem_write, instr_done} !== 5'b0) begin bad++; $display("FAIL trap%0d_strobes[%0d] got=%b want=00000", k, i, {pc_write, ir_write, reg_write, mem_write, instr_done}); end
        cyc();
      end
      #1;
      reset = 1'b1;
      #1;
      total++; if ({state, trap, instret} !== 9'b0) begin bad++; $display("FAIL trap%0d_reset got=%0d/%b/%0d want=0/0/0", k, state, trap, instret); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_ret = 4'd0;
    end
  endtask

  task automatic test_async_reset_memread();
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (state !== 4'd3) begin bad++; $display("FAIL arst_pre got=%0d want=3", state); end
    #1;
    reset = 1'b1;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL arst_state got=%0d want=0", state); end
    total++; if ({pc_write, ir_write, reg_write, mem_write, instr_done, trap} !== 6'b0) begin bad++; $display("FAIL arst_strobes got=%b want=000000", {pc_write, ir_write, reg_write, mem_write, instr_done, trap}); end
    total++; if (instret !== 4'd0) begin bad++; $display("FAIL arst_instret got=%0d want=0", instret); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_ret = 4'd0;
  endtask

  task automatic test_back_to_back_wrap();
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b0;
    for (int n = 0; n < 15; n++) begin
      cyc(); cyc(); cyc();
    end
    total++; if (instret !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d want=15", instret); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL wrap_state got=%0d want=0", state); end
    cyc(); cyc(); cyc();
    total++; if (instret !== 4'd0) begin bad++; $display("FAIL wrap_0 got=%0d want=0", instret); end
  endtask

  initial begin
    #1;
    test_reset();
    test_rtype_sub();
    test_lw_sw();
    test_beq();
    test_alu_decode();
    test_trap();
    test_async_reset_memread();
    test_back_to_back_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
